// File: rtl/noise_gen_pkg.sv
// Shared types and constants for the Gaussian noise generator.
// Holds the FSM states, SIGNAL_TYPE codes, sample-rate constants and per-channel seed/increment helpers.
package noise_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] SIG_TYPE_OFF   = 2'd0;
  localparam logic [1:0] SIG_TYPE_LFM   = 2'd1;
  localparam logic [1:0] SIG_TYPE_PHASE = 2'd2;
  localparam logic [1:0] SIG_TYPE_NOISE = 2'd3;

  localparam int SAMP_FREQ_VALUE_DEF = 1625;
  localparam int SAMP_FREQ_SHIFT_DEF = 3;

  // Channel ch starts at 2^(n_ch-1-ch) - 1, so channel 0 gets the largest seed.
  function automatic logic [63:0] default_seed(input int ch, input int n_ch);
    return (64'd1 << (n_ch - ch - 32'sd1)) - 64'd1;
  endfunction

  function automatic logic [63:0] chan_inc(input int ch);
    return 64'(32'sd2 * ch + 32'sd1);
  endfunction

endpackage

// File: rtl/lcg_channel.sv
// One linear congruential channel: z <= z*(2^L_SHIFT - 1) + INC, modulo 2^LCG_W.
// The top RND_W bits of the current state are exposed as the channel output.
module lcg_channel
  import noise_gen_pkg::*;
#(
  parameter int               LCG_W   = 36,
  parameter int               RND_W   = 12,
  parameter int               L_SHIFT = 5,
  parameter logic [LCG_W-1:0] INC     = {{(LCG_W-1){1'b0}}, 1'b1}
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [LCG_W-1:0] seed,
  input  logic             step,
  output logic [RND_W-1:0] rnd
);

  logic [LCG_W-1:0] z;

  // State update; the multiply by 2^L_SHIFT-1 is a shift and a subtract.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      z <= {LCG_W{1'b0}};
    end else if (load) begin
      z <= seed;
    end else if (step) begin
      z <= (z << L_SHIFT) - z + INC;
    end else begin
      z <= z;
    end
  end

  assign rnd = z[LCG_W-1 -: RND_W];

endmodule

// File: rtl/gauss_noise_gen.sv
// N_CH parallel LCG channels whose top bits are summed into an approximately Gaussian sample.
// Packet control: accept in IDLE, RUN for num samples (or until ABORT), one DRAIN cycle, back to IDLE.
module gauss_noise_gen
  import noise_gen_pkg::*;
#(
  parameter int         N_CH              = 12,
  parameter int         LCG_W             = 36,
  parameter int         RND_W             = 12,
  parameter int         L_SHIFT           = 5,
  parameter int         T_W               = 10,
  parameter int         SAMP_FREQ_VALUE   = SAMP_FREQ_VALUE_DEF,
  parameter int         SAMP_FREQ_SHIFT   = SAMP_FREQ_SHIFT_DEF,
  parameter int         CNT_W             = 32,
  parameter logic [1:0] NOISE_SIGNAL_TYPE = SIG_TYPE_NOISE,
  localparam int        SUM_W             = RND_W + $clog2(N_CH)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [1:0]            SIGNAL_TYPE,
  input  logic [T_W-1:0]        T_IMPULSE,
  input  logic [LCG_W-1:0]      SEED_IN,
  input  logic                  SIGN_START_GEN,
  input  logic                  OUT_REG_READY,
  input  logic                  ABORT,
  output logic                  SIGN_START_CALC,
  output logic                  SIGN_STOP_CALC,
  output logic                  SUM_START,
  output logic                  SUM_STOP,
  output logic [N_CH*RND_W-1:0] RND_BUS,
  output logic                  RND_VALID,
  output logic [SUM_W-1:0]      NOISE_SUM,
  output logic                  NOISE_VALID,
  output logic                  BUSY
);

  state_t                  state, state_next;
  logic                    accept, do_step, do_clear, stop_next;
  logic [CNT_W-1:0]        cnt, num, num_calc;
  logic [N_CH*RND_W-1:0]   rnd_all, rnd_bus;
  logic                    rnd_valid, noise_valid, start_pulse, stop_pulse;
  logic [SUM_W-1:0]        sum, noise_sum;

  assign num_calc = (CNT_W'(T_IMPULSE) * CNT_W'(SAMP_FREQ_VALUE)) << SAMP_FREQ_SHIFT;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [LCG_W-1:0] seed;
    // A load with a zero seed doubles as the channel clear in DRAIN/abort.
    assign seed = accept ? (LCG_W'(default_seed(i, N_CH)) ^ SEED_IN) : {LCG_W{1'b0}};

    lcg_channel #(
      .LCG_W  (LCG_W),
      .RND_W  (RND_W),
      .L_SHIFT(L_SHIFT),
      .INC    (LCG_W'(chan_inc(i)))
    ) u_lcg (
      .CLK  (CLK),
      .RESET(RESET),
      .load (accept | do_clear),
      .seed (seed),
      .step (do_step),
      .rnd  (rnd_all[i*RND_W +: RND_W])
    );
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and datapath strobes; RUN stays one extra cycle after the last sample so STOP shows with it.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    do_step    = 1'b0;
    do_clear   = 1'b0;
    stop_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (SIGN_START_GEN && OUT_REG_READY && (SIGNAL_TYPE == NOISE_SIGNAL_TYPE)) begin
          accept = 1'b1;
          if (num_calc == {CNT_W{1'b0}}) begin
            stop_next  = 1'b1;
            state_next = ST_DRAIN;
          end else begin
            state_next = ST_RUN;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ABORT) begin
          do_clear   = 1'b1;
          stop_next  = (cnt != num);
          state_next = ST_DRAIN;
        end else if (cnt == num) begin
          do_clear   = 1'b1;
          state_next = ST_DRAIN;
        end else begin
          do_step   = 1'b1;
          stop_next = (cnt == num - CNT_W'(1'b1));
        end
      end
      ST_DRAIN: begin
        do_clear   = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Adder tree over the registered channel slices.
  always_comb begin
    sum = {SUM_W{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      sum = sum + SUM_W'(rnd_bus[i*RND_W +: RND_W]);
    end
  end

  // Counters, pulses, sample register and sum stage.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt         <= {CNT_W{1'b0}};
      num         <= {CNT_W{1'b0}};
      start_pulse <= 1'b0;
      stop_pulse  <= 1'b0;
      rnd_bus     <= {(N_CH*RND_W){1'b0}};
      rnd_valid   <= 1'b0;
      noise_sum   <= {SUM_W{1'b0}};
      noise_valid <= 1'b0;
    end else begin
      start_pulse <= accept;
      stop_pulse  <= stop_next;
      if (accept) begin
        num <= num_calc;
        cnt <= {CNT_W{1'b0}};
      end else if (do_step) begin
        cnt <= cnt + CNT_W'(1'b1);
      end else begin
        cnt <= cnt;
      end
      if (do_step) begin
        rnd_bus   <= rnd_all;
        rnd_valid <= 1'b1;
      end else begin
        rnd_bus   <= {(N_CH*RND_W){1'b0}};
        rnd_valid <= 1'b0;
      end
      noise_sum   <= sum;
      noise_valid <= rnd_valid;
    end
  end

  assign SIGN_START_CALC = start_pulse;
  assign SUM_START       = start_pulse;
  assign SIGN_STOP_CALC  = stop_pulse;
  assign SUM_STOP        = stop_pulse;
  assign RND_BUS         = rnd_bus;
  assign RND_VALID       = rnd_valid;
  assign NOISE_SUM       = noise_sum;
  assign NOISE_VALID     = noise_valid;
  assign BUSY            = (state != ST_IDLE);

endmodule

// File: tb/tb_gauss_noise_gen.sv
// Self-checking bench for gauss_noise_gen: gating table plus cycle-accurate packet runs
// compared against an arithmetic LCG model.
module tb_gauss_noise_gen;
  import noise_gen_pkg::*;

  localparam int N_CH  = 12;
  localparam int LCG_W = 36;
  localparam int RND_W = 12;
  localparam int L_SHIFT = 5;
  localparam int T_W   = 10;
  localparam int SUM_W = RND_W + $clog2(N_CH);
  localparam int BUS_W = N_CH * RND_W;
  localparam longint unsigned Z_MASK = (64'd1 << LCG_W) - 64'd1;
  localparam longint unsigned MULT   = (64'd1 << L_SHIFT) - 64'd1;
  localparam int SAMPLES_PER_US = 13000;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [1:0]       SIGNAL_TYPE;
  logic [T_W-1:0]   T_IMPULSE;
  logic [LCG_W-1:0] SEED_IN;
  logic             SIGN_START_GEN, OUT_REG_READY, ABORT;
  logic             SIGN_START_CALC, SIGN_STOP_CALC, SUM_START, SUM_STOP;
  logic [BUS_W-1:0] RND_BUS;
  logic             RND_VALID, NOISE_VALID, BUSY;
  logic [SUM_W-1:0] NOISE_SUM;

  int checks   = 0;
  int failures = 0;

  gauss_noise_gen #(.N_CH(N_CH), .LCG_W(LCG_W), .RND_W(RND_W), .L_SHIFT(L_SHIFT), .T_W(T_W)) dut (
    .CLK(CLK), .RESET(RESET), .SIGNAL_TYPE(SIGNAL_TYPE), .T_IMPULSE(T_IMPULSE), .SEED_IN(SEED_IN),
    .SIGN_START_GEN(SIGN_START_GEN), .OUT_REG_READY(OUT_REG_READY), .ABORT(ABORT),
    .SIGN_START_CALC(SIGN_START_CALC), .SIGN_STOP_CALC(SIGN_STOP_CALC),
    .SUM_START(SUM_START), .SUM_STOP(SUM_STOP), .RND_BUS(RND_BUS), .RND_VALID(RND_VALID),
    .NOISE_SUM(NOISE_SUM), .NOISE_VALID(NOISE_VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]     st;
    logic           rdy;
    logic [T_W-1:0] t;
    logic           e_start;
    logic           e_stop;
    logic           e_busy0;
    logic           e_valid1;
    logic           e_busy1;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_start"}, SIGN_START_CALC, 1'b0);
    chk({tag, "_sum_start"}, SUM_START, 1'b0);
    chk({tag, "_stop"}, SIGN_STOP_CALC, 1'b0);
    chk({tag, "_sum_stop"}, SUM_STOP, 1'b0);
    chk({tag, "_rnd_valid"}, RND_VALID, 1'b0);
    chk({tag, "_rnd_bus"}, RND_BUS, {BUS_W{1'b0}});
    chk({tag, "_noise_valid"}, NOISE_VALID, 1'b0);
    chk({tag, "_noise_sum"}, NOISE_SUM, {SUM_W{1'b0}});
    chk({tag, "_busy"}, BUSY, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    SIGNAL_TYPE = 2'd0; T_IMPULSE = '0; SEED_IN = '0;
    SIGN_START_GEN = 1'b0; OUT_REG_READY = 1'b0; ABORT = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk_quiet("reset");
    RESET = 1'b0;
  endtask

  // One packet from accept until two idle cycles past the end, every cycle compared to the model.
  // abort_c / reset_c: cycle (0 = START cycle) during which ABORT / RESET is driven, -1 for none.
  task automatic run_packet(input logic [LCG_W-1:0] seed, input int t_imp, input int abort_c,
                            input int reset_c, input bit busy_req);
    longint unsigned zm[N_CH];
    longint unsigned s, cur_sum, prev_sum;
    logic [BUS_W-1:0] e_bus;
    logic e_valid, e_nvalid;
    int num, nvalid, stop_c, last_busy, nrv, nnv, nstop;
    bit got_reset;
    string cs;

    num = t_imp * SAMPLES_PER_US;
    for (int i = 0; i < N_CH; i++)
      zm[i] = (((64'd1 << (N_CH - 1 - i)) - 64'd1) ^ {28'd0, seed}) & Z_MASK;
    if (num == 0) begin
      nvalid = 0; stop_c = 0; last_busy = 0;
    end else if (abort_c >= 0 && abort_c < num) begin
      nvalid = abort_c; stop_c = abort_c + 1; last_busy = abort_c + 1;
    end else begin
      nvalid = num; stop_c = num; last_busy = num + 1;
    end
    nrv = 0; nnv = 0; nstop = 0; prev_sum = 0; got_reset = 1'b0;

    @(negedge CLK);
    SEED_IN = seed; T_IMPULSE = T_W'(t_imp); SIGNAL_TYPE = SIG_TYPE_NOISE;
    OUT_REG_READY = 1'b1; SIGN_START_GEN = 1'b1;

    for (int c = 0; c <= last_busy + 2; c++) begin
      @(negedge CLK);
      if (reset_c >= 0 && c == reset_c + 1) begin
        chk_quiet("reset_mid_run");
        RESET = 1'b0;
        got_reset = 1'b1;
        break;
      end
      cs = $sformatf("t%0d_c%0d", t_imp, c);
      e_valid  = (c >= 1 && c <= nvalid);
      e_nvalid = (c >= 2 && c <= nvalid + 1);
      e_bus = '0;
      cur_sum = 0;
      if (e_valid) begin
        for (int i = 0; i < N_CH; i++) begin
          s = (zm[i] >> (LCG_W - RND_W)) & 64'hFFF;
          e_bus[i*RND_W +: RND_W] = RND_W'(s);
          cur_sum = cur_sum + s;
          zm[i] = (zm[i] * MULT + 64'(2 * i + 1)) & Z_MASK;
        end
      end
      chk({"start_", cs}, SIGN_START_CALC, c == 0);
      chk({"sum_start_", cs}, SUM_START, c == 0);
      chk({"stop_", cs}, SIGN_STOP_CALC, c == stop_c);
      chk({"sum_stop_", cs}, SUM_STOP, c == stop_c);
      chk({"busy_", cs}, BUSY, c <= last_busy);
      chk({"rnd_valid_", cs}, RND_VALID, e_valid);
      chk({"rnd_bus_", cs}, RND_BUS, e_bus);
      chk({"noise_valid_", cs}, NOISE_VALID, e_nvalid);
      chk({"noise_sum_", cs}, NOISE_SUM, e_nvalid ? SUM_W'(prev_sum) : {SUM_W{1'b0}});
      if (seed == '0 && num > 0 && c == 1) chk("first_bus_zero", RND_BUS, {BUS_W{1'b0}});
      if (seed == '0 && num > 0 && c == 2) chk("first_sum_zero", NOISE_SUM, {SUM_W{1'b0}});
      prev_sum = cur_sum;
      nrv   = nrv + int'(RND_VALID);
      nnv   = nnv + int'(NOISE_VALID);
      nstop = nstop + int'(SIGN_STOP_CALC);
      SIGN_START_GEN = busy_req && c >= 2 && c <= 4;
      ABORT = (c == abort_c);
      RESET = (reset_c >= 0 && c == reset_c);
    end
    SIGN_START_GEN = 1'b0;
    ABORT = 1'b0;
    if (got_reset) begin
      chk("reset_no_stop_count", nstop, 0);
    end else begin
      chk($sformatf("rnd_valid_count_t%0d", t_imp), nrv, nvalid);
      chk($sformatf("noise_valid_count_t%0d", t_imp), nnv, nvalid);
      chk($sformatf("stop_count_t%0d", t_imp), nstop, 1);
    end
  endtask

  initial begin
    logic [63:0] r64;
    int          rand_abort;

    vecs[0] = '{SIG_TYPE_NOISE, 1'b1, 10'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{SIG_TYPE_PHASE, 1'b1, 10'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{SIG_TYPE_NOISE, 1'b0, 10'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{SIG_TYPE_LFM,   1'b1, 10'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{SIG_TYPE_NOISE, 1'b1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{SIG_TYPE_OFF,   1'b1, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    RESET = 1'b1;
    SIGNAL_TYPE = 2'd0; T_IMPULSE = '0; SEED_IN = '0;
    SIGN_START_GEN = 1'b0; OUT_REG_READY = 1'b0; ABORT = 1'b0;

    for (int k = 0; k < 6; k++) begin
      do_reset();
      @(negedge CLK);
      SIGNAL_TYPE = vecs[k].st; OUT_REG_READY = vecs[k].rdy; T_IMPULSE = vecs[k].t;
      SIGN_START_GEN = 1'b1;
      @(negedge CLK);
      SIGN_START_GEN = 1'b0;
      chk($sformatf("vec%0d_start", k), SIGN_START_CALC, vecs[k].e_start);
      chk($sformatf("vec%0d_sum_start", k), SUM_START, vecs[k].e_start);
      chk($sformatf("vec%0d_stop", k), SIGN_STOP_CALC, vecs[k].e_stop);
      chk($sformatf("vec%0d_busy0", k), BUSY, vecs[k].e_busy0);
      chk($sformatf("vec%0d_valid0", k), RND_VALID, 1'b0);
      @(negedge CLK);
      chk($sformatf("vec%0d_valid1", k), RND_VALID, vecs[k].e_valid1);
      chk($sformatf("vec%0d_busy1", k), BUSY, vecs[k].e_busy1);
      chk($sformatf("vec%0d_start1", k), SIGN_START_CALC, 1'b0);
      chk($sformatf("vec%0d_stop1", k), SIGN_STOP_CALC, 1'b0);
    end

    do_reset();
    run_packet('0, 1, -1, -1, 1'b1);
    run_packet('0, 0, -1, -1, 1'b0);
    run_packet('0, 1, 100, -1, 1'b0);
    run_packet('0, 1, SAMPLES_PER_US, -1, 1'b0);
    run_packet('0, 1, SAMPLES_PER_US - 1, -1, 1'b0);
    run_packet('0, 1, -1, 50, 1'b0);
    run_packet(36'd5, 1, -1, -1, 1'b0);

    r64 = {$urandom(), $urandom()};
    rand_abort = int'($urandom_range(1, 400));
    run_packet(r64[LCG_W-1:0], 1, rand_abort, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gauss_noise_gen.md
Name: gauss_noise_gen

Overview:
Parametrised successor to the 12-channel congruent noise source. It runs N_CH LCG channels in parallel and exposes their top bits as a flat bus. A registered adder stage sums the channels into one approximately Gaussian sample (CLT), so the output register no longer needs an external summer. Adds a runtime seed, abort, valid strobes, zero-length handling and defined (non-Z) idle outputs. Sits between the control decoder and the output register, beside the LFM/phase generators.

Parameters:
N_CH, 12, number of LCG channels (2..16)
LCG_W, 36, LCG state width
RND_W, 12, bits taken per channel: z[LCG_W-1 -: RND_W]
L_SHIFT, 5, multiplier = 2^L_SHIFT - 1
T_W, 10, T_IMPULSE width
SAMP_FREQ_VALUE, 1625, sample-rate mantissa (MHz)
SAMP_FREQ_SHIFT, 3, sample-rate shift; Fs = 13000 MHz
CNT_W, 32, sample counter width
NOISE_SIGNAL_TYPE, 3, SIGNAL_TYPE code served
SUM_W (local), RND_W + $clog2(N_CH), sum width

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
SIGNAL_TYPE  in  2  selected generator
T_IMPULSE  in  T_W  pulse length, us
SEED_IN  in  LCG_W  XOR-ed into default seeds at start
SIGN_START_GEN  in  1  start request
OUT_REG_READY  in  1  output register ready
ABORT  in  1  terminate the current packet
SIGN_START_CALC  out  1  one-cycle packet-start pulse
SIGN_STOP_CALC  out  1  one-cycle packet-stop pulse
SUM_START  out  1  copy of SIGN_START_CALC
SUM_STOP  out  1  copy of SIGN_STOP_CALC
RND_BUS  out  N_CH*RND_W  channel i at [i*RND_W +: RND_W]
RND_VALID  out  1  RND_BUS holds a sample
NOISE_SUM  out  SUM_W  unsigned sum of all channels
NOISE_VALID  out  1  NOISE_SUM holds a sample
BUSY  out  1  state != IDLE

Behaviour:
- Reset (any state): state=IDLE. All outputs 0. Counters 0. All z 0.
- States: IDLE, RUN, DRAIN.
- Accept in IDLE when SIGN_START_GEN & OUT_REG_READY & SIGNAL_TYPE==NOISE_SIGNAL_TYPE. All other cases are ignored. Requests outside IDLE are ignored.
- On accept:
  - num = (T_IMPULSE*SAMP_FREQ_VALUE) << SAMP_FREQ_SHIFT, computed at CNT_W. Max 1023*13000 fits.
  - z_i <= ((1<<(N_CH-1-i)) - 1) ^ SEED_IN, for i = 0..N_CH-1. With SEED_IN=0 and N_CH=12 this gives 2047..0.
  - cnt <= 0.
  - SIGN_START_CALC and SUM_START are high for the next cycle only.
  - Next state is RUN, or DRAIN if num == 0.
- RUN, every cycle:
  - z_i <= (z_i<<L_SHIFT) - z_i + (2i+1), mod 2^LCG_W.
  - RND slice i <= z_i top RND_W bits (pre-update value).
  - RND_VALID <= 1.
  - cnt <= cnt + 1.
  - The first RND_BUS sample therefore comes from the seeds.
- Last sample (cnt == num-1):
  - SIGN_STOP_CALC and SUM_STOP pulse on the same cycle that RND_VALID shows the last sample.
  - Next state is DRAIN.
- Zero-length packet (num == 0): START and STOP pulses coincide (the cycle after accept). No RND_VALID or NOISE_VALID is produced.
- Sum stage:
  - NOISE_SUM <= sum over channels of RND_BUS slices.
  - NOISE_VALID <= RND_VALID.
  - Fixed latency of 1 cycle after RND_BUS.
- DRAIN (one cycle):
  - RND_VALID <= 0, RND_BUS <= 0, z <= 0.
  - Sum stage flushes the final sample.
  - Next state is IDLE.
  - In the cycle after DRAIN, NOISE_VALID = 0 and NOISE_SUM = 0.
- Exactly num RND_VALID cycles and num NOISE_VALID cycles per packet, each contiguous.
- ABORT in RUN:
  - Takes priority over the normal step.
  - No new sample is produced that cycle.
  - STOP pulses the next cycle if one was not already pulsed; DRAIN follows.
  - ABORT is ignored in IDLE and DRAIN.
- ABORT and last-sample in the same cycle: ABORT wins. STOP pulses once only.
- RESET mid-packet: immediate return to IDLE. No STOP pulse.
- OUT_REG_READY is sampled only at accept. There is no back-pressure during RUN.
- BUSY = (state != IDLE).

Decomposition:
- noise_gen_pkg holds:
  - state enum (IDLE/RUN/DRAIN);
  - NOISE_SIGNAL_TYPE and the other SIGNAL_TYPE codes;
  - SAMP_FREQ_VALUE/SHIFT;
  - a function computing the default seed;
  - a function computing the channel increment 2i+1.
- One sub-module, lcg_channel (parameters LCG_W, RND_W, L_SHIFT, INC). Ports: CLK, RESET, load, seed, step, rnd. Instantiated N_CH times via generate.
- FSM, counter and adder stage stay in the top level.

Test Plan:
- Nominal packet (N_CH=12, SEED_IN=0, T_IMPULSE=1, SIGNAL_TYPE=3, READY=1):
  - START pulse the cycle after accept;
  - exactly 13000 RND_VALID cycles;
  - STOP coincident with the 13000th sample;
  - NOISE_VALID delayed by exactly 1 cycle;
  - BUSY drops 2 cycles after STOP.
- Determinism check against a reference model:
  - first sample: all slices 0 and NOISE_SUM = 0 (seeds are small);
  - RND_BUS matches the model for all 13000 samples;
  - NOISE_SUM equals the sum of the slices every cycle.
- Gating:
  - SIGNAL_TYPE=2, or READY=0, or a request while BUSY -> no START, outputs stay 0;
  - T_IMPULSE=0 -> START and STOP in the same cycle, zero valid cycles.
- Abort: ABORT at sample 100 -> exactly 100 RND_VALID cycles, a single STOP on the next cycle, then DRAIN and IDLE. ABORT on the last sample -> one STOP only.
- Reset mid-RUN (sample 50) -> all outputs 0 on the next cycle and no STOP. A fresh start with SEED_IN=5 reproduces the model sequence for that seed.
